ifu_fetch: RTL and testbench

Instruction fetch unit that sits directly upstream of the core. It holds the fetch PC and issues in-order word requests to instruction memory. Returned words are buffered with their PCs in a small prefetch FIFO, which presents instructions to the core through a valid/ready handshake. Branch/jump/exception redirects from the core flush the FIFO, and the unit discards responses from requests already in flight.

---
 rtl/ifu_fetch.sv | 127 ++++++++++++
 tb/tb_ifu_fetch.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: credit-limited in-order word fetch into a small
// prefetch FIFO, presented to the core over valid/ready, with redirect flush.
module ifu_fetch #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = 'hBFC0_0000,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,

    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,

    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,

    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] resp_pc;

    logic              credit_ok;
    logic              accept;
    logic              resp;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic [ADDR_W-1:0] redirect_aligned;
    entry_t            head;

    // Every slot is either buffered or in flight, so the FIFO can never overflow.
    always_comb begin
        credit_ok        = ({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_SUM;
        imem_req         = rst && credit_ok && !redirect_valid;
        imem_addr        = pc;
        accept           = imem_req && imem_gnt;
        resp             = imem_rvalid && (outstanding != '0);
        push             = resp && !redirect_valid && (drop == '0);
        fifo_full        = (fifo_count == DEPTH_CNT);
        inst_valid       = (fifo_count != '0);
        pop              = inst_valid && inst_ready && !redirect_valid;
        redirect_aligned = redirect_pc & ~ADDR_W'(3);
        head             = fifo_mem[rd_ptr];
        inst_data        = inst_valid ? head.data : '0;
        inst_pc          = inst_valid ? head.pc   : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight predates the redirect and must be dropped.
            pc          <= redirect_aligned;
            resp_pc     <= redirect_aligned;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= outstanding - CNT_W'(resp);
            drop        <= outstanding - CNT_W'(resp);
        end else begin
            if (accept) begin
                pc <= pc + PC_STEP;
            end
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(resp);
            if (resp && (drop != '0)) begin
                drop <= drop - CNT_W'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + PC_STEP;
                wr_ptr  <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by fifo_count and
    // the head is masked to zero while empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{pc: resp_pc, data: imem_rdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(push && fifo_full));
            assert ({1'b0, outstanding} <= DEPTH_SUM);
            assert (drop <= outstanding);
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: a transaction-level model (queues of in-flight
// requests and buffered instructions) predicts every output each cycle.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam int          DEPTH    = 4;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    ifu_fetch #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ins_t;

    req_t        q_mem[$];
    ins_t        q_fifo[$];
    logic [31:0] q_late[$];
    logic [31:0] m_pc;
    logic [31:0] data_key;
    int          cyc;
    int          dly_min;
    int          dly_max;
    int          p_rv;
    int          n_checks;
    int          n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   imem_req,   1'b0);
        check({tag, "_addr"},  imem_addr,  RESET_PC);
        check({tag, "_valid"}, inst_valid, 1'b0);
        check({tag, "_data"},  inst_data,  32'h0);
        check({tag, "_pc"},    inst_pc,    32'h0);
    endtask

    // One clock cycle: drive inputs at the falling edge, check, predict the rising edge.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit gnt_i, input bit ready_i);
        bit          rv;
        bit          g;
        bit          exp_req;
        bit          exp_valid;
        logic [31:0] rdata;
        req_t        e;
        ins_t        ins;
        rv    = 1'b0;
        g     = gnt_i;
        rdata = $urandom;
        if (q_late.size() != 0) begin
            rv = 1'b1;
            g  = 1'b0;
        end else if (q_mem.size() != 0 && q_mem[0].due <= cyc && int'($urandom_range(99)) < p_rv) begin
            rv    = 1'b1;
            rdata = q_mem[0].addr ^ data_key;
        end
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_gnt       = g;
        inst_ready     = ready_i;
        imem_rvalid    = rv;
        imem_rdata     = rdata;
        #1;
        exp_req   = (q_fifo.size() + q_mem.size() < DEPTH) && !redir;
        exp_valid = (q_fifo.size() != 0);
        check("imem_req",   imem_req,   exp_req);
        check("imem_addr",  imem_addr,  m_pc);
        check("inst_valid", inst_valid, exp_valid);
        if (exp_valid) begin
            check("inst_pc",   inst_pc,   q_fifo[0].pc);
            check("inst_data", inst_data, q_fifo[0].data);
        end
        if (q_late.size() != 0) begin
            void'(q_late.pop_front());
        end else if (redir) begin
            q_fifo.delete();
            if (rv) void'(q_mem.pop_front());
            for (int i = 0; i < q_mem.size(); i++) begin
                e          = q_mem[i];
                e.stale    = 1'b1;
                q_mem[i]   = e;
            end
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (exp_valid && ready_i) void'(q_fifo.pop_front());
            if (rv) begin
                e = q_mem.pop_front();
                if (!e.stale) begin
                    ins.pc   = e.addr;
                    ins.data = e.addr ^ data_key;
                    q_fifo.push_back(ins);
                end
            end
            if (exp_req && g) begin
                e.addr  = m_pc;
                e.due   = cyc + 1 + dly_min + int'($urandom_range(dly_max - dly_min));
                e.stale = 1'b0;
                q_mem.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int p_gnt;
        int p_rdy;

        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        dly_min  = 0;
        dly_max  = 0;
        p_rv     = 100;
        data_key = 32'h0;
        m_pc     = RESET_PC;
        rst            = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Streaming with a 1-cycle memory returning the address as data.
        repeat (20) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Core stall fills the FIFO, then drains it in order.
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Slow memory with requests in flight, then a redirect.
        dly_min = 2;
        dly_max = 2;
        found   = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (q_mem.size() >= 2) found = 1'b1;
            else step(1'b0, 32'h0, 1'b1, 1'b1);
        end
        check("slow_mem_setup", found, 1'b1);
        step(1'b1, 32'h8000_0100, 1'b1, 1'b1);
        repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect coinciding with a response and a head handshake.
        dly_min = 0;
        dly_max = 1;
        found   = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (q_fifo.size() != 0 && q_mem.size() != 0 && q_mem[0].due <= cyc) found = 1'b1;
            else step(1'b0, 32'h0, 1'b1, 1'b1);
        end
        check("redirect_rvalid_setup", found, 1'b1);
        step(1'b1, $urandom, 1'b1, 1'b1);
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Grant withheld for five cycles with a redirect in the middle.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h0000_1003, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);

        // PC wrap-around at the top of the address space.
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Randomized traffic, knobs reshuffled every 100 cycles.
        p_gnt = 100;
        p_rdy = 100;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                p_gnt    = 20 + int'($urandom_range(80));
                p_rdy    = 20 + int'($urandom_range(80));
                p_rv     = 50 + int'($urandom_range(50));
                dly_min  = 0;
                dly_max  = int'($urandom_range(3));
                data_key = $urandom;
            end
            step($urandom_range(99) < 3, $urandom,
                 int'($urandom_range(99)) < p_gnt, int'($urandom_range(99)) < p_rdy);
        end

        // Asynchronous reset mid-stream; late responses must be ignored afterwards.
        p_rv    = 100;
        dly_min = 2;
        dly_max = 2;
        found   = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (q_mem.size() >= 2 && q_fifo.size() >= 1) found = 1'b1;
            else step(1'b0, 32'h0, 1'b1, 1'b1);
        end
        check("midstream_setup", found, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        for (int i = 0; i < q_mem.size(); i++) q_late.push_back(q_mem[i].addr);
        q_mem.delete();
        q_fifo.delete();
        m_pc           = RESET_PC;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (25) step(1'b0, 32'h0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
